// File: rtl/elastic_pkg.sv
// Shared constants and elaboration-time helpers for the elastic buffer.
package elastic_pkg;

    localparam int unsigned FT_OFF = 0;
    localparam int unsigned FT_ON  = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            x = x >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit depth_ok(input int unsigned d);
        return (d >= 2) && (d <= 256) && ((d & (d - 1)) == 0);
    endfunction

    function automatic bit afull_ok(input int unsigned a, input int unsigned d);
        return (a >= 1) && (a <= d);
    endfunction

endpackage

// File: rtl/elastic_buffer_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, no reset on the array.
module elastic_buffer_mem
    import elastic_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AW     = 2
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/elastic_buffer.sv
// DEPTH-entry valid/ready elastic buffer with optional fall-through, flush and level status.
module elastic_buffer
    import elastic_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FALLTHROUGH = FT_OFF,
    parameter int unsigned AFULL_LVL   = DEPTH - 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [DATA_W-1:0]           up_data,
    input  logic                        up_valid,
    output logic                        up_ready,
    output logic [DATA_W-1:0]           down_data,
    output logic                        down_valid,
    input  logic                        down_ready,
    output logic [clog2(DEPTH+1)-1:0]   level,
    output logic                        almost_full
);

    localparam int unsigned      CNT_W    = clog2(DEPTH + 1);
    localparam int unsigned      PTR_W    = clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AFULL_LVL);
    localparam bit               FT       = (FALLTHROUGH == FT_ON);

    if (!depth_ok(DEPTH)) begin : g_depth_chk
        $error("elastic_buffer: DEPTH must be a power of two in 2..256");
    end
    if (!afull_ok(AFULL_LVL, DEPTH)) begin : g_afull_chk
        $error("elastic_buffer: AFULL_LVL must lie in 1..DEPTH");
    end

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic              stored, push, pop, wr_en, rd_adv;
    logic [DATA_W-1:0] rd_data;

    assign stored      = (level_q != '0);
    assign up_ready    = !rst && !flush && (level_q != FULL_LVL);
    assign down_valid  = !rst && (stored || (FT && up_valid));
    assign down_data   = (FT && !stored) ? up_data : rd_data;
    assign level       = level_q;
    assign almost_full = (level_q >= AF_LVL);

    assign push = up_valid && up_ready;
    assign pop  = down_valid && down_ready;
    // An empty fall-through buffer hands the word straight across instead of storing it.
    assign wr_en  = push && !(FT && !stored && pop);
    assign rd_adv = pop && stored && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_adv) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_adv})
                2'b10:   level_d = level_q + CNT_W'(1);
                2'b01:   level_d = level_q - CNT_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    elastic_buffer_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (up_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (level_q == FULL_LVL)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && !down_valid));

endmodule
